register_file_32x32: RTL and testbench

REGISTER_FILE_32X32 -- requirements
Module: register_file_32x32

---
 rtl/register_file_32x32.sv | 62 ++++++
 tb/tb_register_file_32x32.sv | 149 ++++++++++++++
 2 files changed

// File: rtl/register_file_32x32.sv
// register_file_32x32: 32x32 register file, combinational reads, clear-sweep FSM; REGFILE_BYPASS_EN enables write-to-read bypass
module register_file_32x32 #(
  parameter logic [31:0] CLEAR_VALUE = 32'h0000_0000
) (
  input  logic        Clk,
  input  logic        ResetN,
  input  logic [4:0]  ReadRegister1,
  input  logic [4:0]  ReadRegister2,
  output logic [31:0] ReadData1,
  output logic [31:0] ReadData2,
  input  logic [4:0]  WriteRegister,
  input  logic [31:0] WriteData,
  input  logic        RegWrite,
  input  logic        ClearReq,
  output logic        ClearBusy,
  output logic        ClearDone
);
  typedef enum logic [1:0] {IDLE, SWEEP, DONE} state_t;
  state_t state, state_next;
  logic [4:0] cnt;
  logic [31:0] mem [32];
  logic wr_en;
  assign ClearBusy = state != IDLE;
  assign ClearDone = state == DONE;
  assign wr_en = RegWrite && WriteRegister != 5'd0 && !ClearBusy;
  // next state: sweep starts on a request, ends after r31, holds DONE one cycle
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    state_next = ClearReq ? SWEEP : IDLE;
      SWEEP:   state_next = (cnt == 5'd31) ? DONE : SWEEP;
      default: state_next = IDLE;
    endcase
  end
  // state and sweep counter; the counter saturates at 31 instead of wrapping
  always_ff @(posedge Clk) begin
    if (!ResetN) begin
      state <= IDLE;
      cnt <= 5'd0;
    end else begin
      state <= state_next;
      cnt <= (state == IDLE && ClearReq) ? 5'd1 : (state == SWEEP && cnt != 5'd31) ? cnt + 5'd1 : cnt;
    end
  end
  // storage: the sweep owns the write port while busy, user writes are dropped
  always_ff @(posedge Clk) begin
    if (!ResetN) begin
      for (int i = 0; i < 32; i++) mem[i] <= '0;
    end else if (state == SWEEP) begin
      mem[cnt] <= CLEAR_VALUE;
    end else if (wr_en) begin
      mem[WriteRegister] <= WriteData;
    end
  end
`ifdef REGFILE_BYPASS_EN
  assign ReadData1 = (ReadRegister1 == 5'd0) ? '0 : (wr_en && WriteRegister == ReadRegister1) ? WriteData : mem[ReadRegister1];
  assign ReadData2 = (ReadRegister2 == 5'd0) ? '0 : (wr_en && WriteRegister == ReadRegister2) ? WriteData : mem[ReadRegister2];
`else
  assign ReadData1 = (ReadRegister1 == 5'd0) ? '0 : mem[ReadRegister1];
  assign ReadData2 = (ReadRegister2 == 5'd0) ? '0 : mem[ReadRegister2];
`endif
endmodule

// File: tb/tb_register_file_32x32.sv
// tb_register_file_32x32: table vectors with a scoreboard queue plus sweep, reset and bypass sequences
module tb_register_file_32x32;
  localparam logic [31:0] CV = 32'hA5A5_A5A5;
  logic Clk = 0;
  logic ResetN, RegWrite, ClearReq, ClearBusy, ClearDone;
  logic [4:0] ReadRegister1, ReadRegister2, WriteRegister;
  logic [31:0] ReadData1, ReadData2, WriteData;
  int checks = 0;
  int errors = 0;
  typedef struct {
    logic        we;
    logic [4:0]  wa;
    logic [31:0] wd;
    logic [4:0]  r1;
    logic [4:0]  r2;
    logic [31:0] e1;
    logic [31:0] e2;
  } vec_t;
  vec_t vecs[7];
  logic [31:0] sb[$];
  register_file_32x32 #(.CLEAR_VALUE(CV)) dut (
    .Clk(Clk), .ResetN(ResetN),
    .ReadRegister1(ReadRegister1), .ReadRegister2(ReadRegister2),
    .ReadData1(ReadData1), .ReadData2(ReadData2),
    .WriteRegister(WriteRegister), .WriteData(WriteData), .RegWrite(RegWrite),
    .ClearReq(ClearReq), .ClearBusy(ClearBusy), .ClearDone(ClearDone)
  );
  always #5 Clk = ~Clk;
  task automatic tick;
    @(posedge Clk);
    #1;
  endtask
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  initial begin
    int n, dones, done_at;
    logic [31:0] e;
    vecs[0] = '{1'b1, 5'd5,  32'hDEAD_BEEF, 5'd5,  5'd0,  32'hDEAD_BEEF, 32'h0};
    vecs[1] = '{1'b1, 5'd0,  32'hFFFF_FFFF, 5'd0,  5'd5,  32'h0,         32'hDEAD_BEEF};
    vecs[2] = '{1'b1, 5'd31, 32'h1234_5678, 5'd31, 5'd5,  32'h1234_5678, 32'hDEAD_BEEF};
    vecs[3] = '{1'b1, 5'd1,  32'h0000_0001, 5'd1,  5'd31, 32'h1,         32'h1234_5678};
    vecs[4] = '{1'b0, 5'd7,  32'h0000_0055, 5'd7,  5'd1,  32'h0,         32'h1};
    vecs[5] = '{1'b1, 5'd5,  32'h0000_0001, 5'd5,  5'd1,  32'h1,         32'h1};
    vecs[6] = '{1'b1, 5'd12, 32'hFFFF_FFFF, 5'd12, 5'd13, 32'hFFFF_FFFF, 32'h0};
    ResetN = 0; RegWrite = 0; ClearReq = 0; WriteRegister = 0; WriteData = 0;
    ReadRegister1 = 5; ReadRegister2 = 31;
    tick;
    tick;
    ResetN = 1;
    #1;
    chk("reset_rd1", ReadData1, 32'h0);
    chk("reset_busy", {31'b0, ClearBusy}, 32'h0);
    chk("reset_done", {31'b0, ClearDone}, 32'h0);
    for (int i = 0; i < 7; i++) begin
      RegWrite = vecs[i].we; WriteRegister = vecs[i].wa; WriteData = vecs[i].wd;
      ReadRegister1 = vecs[i].r1; ReadRegister2 = vecs[i].r2;
      sb.push_back(vecs[i].e1);
      sb.push_back(vecs[i].e2);
      tick;
      RegWrite = 0;
      #1;
      e = sb.pop_front();
      chk($sformatf("vec%0d_rd1", i), ReadData1, e);
      e = sb.pop_front();
      chk($sformatf("vec%0d_rd2", i), ReadData2, e);
    end
    RegWrite = 1; WriteRegister = 9; WriteData = 32'hCAFE_0001;
    ReadRegister1 = 9; ReadRegister2 = 0;
    #1;
`ifdef REGFILE_BYPASS_EN
    chk("bypass_same_cycle", ReadData1, 32'hCAFE_0001);
`else
    chk("no_bypass_old", ReadData1, 32'h0);
`endif
    chk("bypass_r0", ReadData2, 32'h0);
    tick;
    RegWrite = 0;
    #1;
    chk("bypass_after_edge", ReadData1, 32'hCAFE_0001);
    ClearReq = 1; RegWrite = 1; WriteRegister = 30; WriteData = 32'h77;
    tick;
    ClearReq = 0; RegWrite = 0;
    n = 0; dones = 0; done_at = 0;
    while (ClearBusy && n < 60) begin
      n++;
      if (ClearDone) begin
        dones++;
        done_at = n;
      end
      if (n == 2) begin
        ReadRegister1 = 1; ReadRegister2 = 31;
        #1;
        chk("sweep_r1_swept", ReadData1, CV);
        chk("sweep_r31_unswept", ReadData2, 32'h1234_5678);
        ReadRegister1 = 30;
        #1;
        chk("sweep_r30_same_edge_write", ReadData1, 32'h77);
      end
      RegWrite = (n == 10);
      WriteRegister = 3; WriteData = 32'h7;
      ClearReq = (n == 32);
      tick;
      ClearReq = 0; RegWrite = 0;
    end
    chk("sweep_busy_cycles", n, 32);
    chk("sweep_done_pulses", dones, 1);
    chk("sweep_done_cycle", done_at, 32);
    tick;
    chk("sweep_req_in_done_ignored", {31'b0, ClearBusy}, 32'h0);
    ReadRegister1 = 1; ReadRegister2 = 31;
    #1;
    chk("post_sweep_r1", ReadData1, CV);
    chk("post_sweep_r31", ReadData2, CV);
    ReadRegister1 = 0; ReadRegister2 = 3;
    #1;
    chk("post_sweep_r0", ReadData1, 32'h0);
    chk("post_sweep_r3", ReadData2, CV);
    ClearReq = 1;
    tick;
    ClearReq = 0;
    n = 0; dones = 0;
    while (ClearBusy && n < 60) begin
      n++;
      dones += int'(ClearDone);
      ResetN = (n != 15);
      tick;
    end
    ResetN = 1;
    chk("abort_cycle", n, 15);
    chk("abort_busy", {31'b0, ClearBusy}, 32'h0);
    for (int c = 0; c < 40; c++) begin
      dones += int'(ClearDone);
      tick;
    end
    chk("abort_no_done", dones, 0);
    for (int a = 0; a < 32; a++) begin
      ReadRegister1 = a[4:0]; ReadRegister2 = 5'(31 - a);
      #1;
      chk($sformatf("abort_zero_r%0d", a), ReadData1 | ReadData2, 32'h0);
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
